// File: rtl/time_entry_buffer.sv
// time_entry_buffer: keypad-side writer for the microwave timer digit chain.
// Digits shift in at seconds-units; on start the MM:SS buffer is normalized
// (seconds >= 60 folded into minutes, saturating at 99:59) and a single
// one-cycle load strobe presents the four BCD digits to the timer counters.
//
// Ports:
//   clk          in   system clock, rising edge
//   clear        in   synchronous active-high reset
//   key_valid    in   digit key strobe, key_code valid this cycle
//   key_code     in   BCD digit 0-9 (10-15 ignored)
//   start_key    in   commit buffer to timer
//   cancel_key   in   discard entry
//   timer_busy   in   blocks digit/start entry while the timer counts
//   load         out  one-cycle load strobe to timer digits
//   min_tens     out  BCD minutes tens
//   min_units    out  BCD minutes units
//   sec_tens     out  BCD seconds tens (0-5 whenever load=1)
//   sec_units    out  BCD seconds units
//   entry_active out  high while collecting digits
module time_entry_buffer #(
    parameter int NUM_DIGITS   = 4,
    parameter int MAX_MIN_TENS = 9
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start_key,
    input  logic       cancel_key,
    input  logic       timer_busy,
    output logic       load,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       entry_active
);

    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
    localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        NORMALIZE,
        LOAD
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       mt_q, mt_d;
    logic [3:0]       mu_q, mu_d;
    logic [3:0]       st_q, st_d;
    logic [3:0]       su_q, su_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_q, load_d;
    logic             entry_q, entry_d;

    logic key_ok;
    logic start_ok;
    logic buf_zero;
    logic min_at_max;
    logic sec_over;

    // Keys and start are gated by the busy timer; cancel never is.
    assign key_ok     = key_valid && !timer_busy && (key_code <= 4'd9);
    assign start_ok   = start_key && !timer_busy;
    assign buf_zero   = (mt_q == 4'd0) && (mu_q == 4'd0)
                     && (st_q == 4'd0) && (su_q == 4'd0);
    // ">=" keeps the increment from leaving BCD if the limit is below 9.
    assign min_at_max = (mt_q >= MT_MAX) && (mu_q == 4'd9);
    assign sec_over   = (st_q >= 4'd6);

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mu_d    = mu_q;
        st_d    = st_q;
        su_d    = su_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cancel_key) begin
                    mt_d  = 4'd0;
                    mu_d  = 4'd0;
                    st_d  = 4'd0;
                    su_d  = 4'd0;
                    cnt_d = '0;
                end else if (key_ok) begin
                    mt_d    = 4'd0;
                    mu_d    = 4'd0;
                    st_d    = 4'd0;
                    su_d    = key_code;
                    cnt_d   = CNT_W'(1);
                    state_d = ENTRY;
                end
            end

            ENTRY: begin
                if (cancel_key) begin
                    mt_d    = 4'd0;
                    mu_d    = 4'd0;
                    st_d    = 4'd0;
                    su_d    = 4'd0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (start_ok) begin
                    // An all-zero entry has nothing to time.
                    state_d = buf_zero ? IDLE : NORMALIZE;
                end else if (key_ok && (cnt_q < CNT_FULL)) begin
                    mt_d  = mu_q;
                    mu_d  = st_q;
                    st_d  = su_q;
                    su_d  = key_code;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            NORMALIZE: begin
                if (cancel_key) begin
                    mt_d    = 4'd0;
                    mu_d    = 4'd0;
                    st_d    = 4'd0;
                    su_d    = 4'd0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    state_d = LOAD;
                    if (sec_over) begin
                        if (min_at_max) begin
                            st_d = 4'd5;
                            su_d = 4'd9;
                        end else begin
                            st_d = st_q - 4'd6;
                            if (mu_q == 4'd9) begin
                                mu_d = 4'd0;
                                mt_d = mt_q + 4'd1;
                            end else begin
                                mu_d = mu_q + 4'd1;
                            end
                        end
                    end
                end
            end

            LOAD: begin
                // The strobe for this cycle is already registered;
                // cancel only wipes the buffer afterwards.
                state_d = IDLE;
                if (cancel_key) begin
                    mt_d  = 4'd0;
                    mu_d  = 4'd0;
                    st_d  = 4'd0;
                    su_d  = 4'd0;
                    cnt_d = '0;
                end
            end
        endcase

        // Outputs are registered, so derive them from the next state.
        load_d  = (state_d == LOAD);
        entry_d = (state_d == ENTRY);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            mt_q    <= 4'd0;
            mu_q    <= 4'd0;
            st_q    <= 4'd0;
            su_q    <= 4'd0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mu_q    <= mu_d;
            st_q    <= st_d;
            su_q    <= su_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            entry_q <= entry_d;
        end
    end

    assign load         = load_q;
    assign min_tens     = mt_q;
    assign min_units    = mu_q;
    assign sec_tens     = st_q;
    assign sec_units    = su_q;
    assign entry_active = entry_q;

endmodule

// File: tb/tb_time_entry_buffer.sv
// tb_time_entry_buffer: directed vectors for time_entry_buffer.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_time_entry_buffer;

    logic       clk = 1'b0;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start_key;
    logic       cancel_key;
    logic       timer_busy;
    logic       load;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       entry_active;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int p0;

    logic [15:0] digits;
    assign digits = {min_tens, min_units, sec_tens, sec_units};

    time_entry_buffer dut (
        .clk          (clk),
        .clear        (clear),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .start_key    (start_key),
        .cancel_key   (cancel_key),
        .timer_busy   (timer_busy),
        .load         (load),
        .min_tens     (min_tens),
        .min_units    (min_units),
        .sec_tens     (sec_tens),
        .sec_units    (sec_units),
        .entry_active (entry_active)
    );

    always #5 clk = ~clk;

    // Count load pulses, sampled just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (load === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic cancel();
        @(negedge clk);
        cancel_key = 1'b1;
        @(negedge clk);
        cancel_key = 1'b0;
    endtask

    // Start, then expect NORMALIZE, LOAD with exp digits, then idle.
    task automatic start_expect(input string tag, input logic [15:0] exp);
        int base;
        base = pulses;
        @(negedge clk);
        start_key = 1'b1;
        @(negedge clk);
        start_key = 1'b0;
        check({tag, "_norm_load"}, 16'(load), 16'h0);
        check({tag, "_entry_drop"}, 16'(entry_active), 16'h0);
        @(negedge clk);
        check({tag, "_load_hi"}, 16'(load), 16'h1);
        check({tag, "_load_dig"}, digits, exp);
        @(negedge clk);
        check({tag, "_load_lo"}, 16'(load), 16'h0);
        check({tag, "_hold_dig"}, digits, exp);
        check({tag, "_one_pulse"}, 16'(pulses - base), 16'h1);
    endtask

    initial begin
        clear      = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'd0;
        start_key  = 1'b0;
        cancel_key = 1'b0;
        timer_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_load", 16'(load), 16'h0);
        check("rst_dig", digits, 16'h0000);
        check("rst_entry", 16'(entry_active), 16'h0);
        clear = 1'b0;

        // Plain entry 1,3,0.
        press(4'd1);
        check("first_key", digits, 16'h0001);
        check("entry_on", 16'(entry_active), 16'h1);
        press(4'd3);
        press(4'd0);
        check("k130", digits, 16'h0130);
        start_expect("s130", 16'h0130);

        // 90 seconds -> 01:30.
        press(4'd9);
        press(4'd0);
        check("k90", digits, 16'h0090);
        start_expect("s90", 16'h0130);

        // 09:75 -> 10:15, minutes carry.
        press(4'd0);
        press(4'd9);
        press(4'd7);
        press(4'd5);
        check("k0975", digits, 16'h0975);
        start_expect("s0975", 16'h1015);

        // 99:99 saturates to 99:59.
        repeat (4) press(4'd9);
        check("k9999", digits, 16'h9999);
        start_expect("s9999", 16'h9959);

        // Fifth key is dropped.
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        press(4'd5);
        check("k5drop", digits, 16'h1234);
        cancel();
        check("cancel_dig", digits, 16'h0000);
        check("cancel_entry", 16'(entry_active), 16'h0);

        // Cancel beats start in the same cycle.
        p0 = pulses;
        press(4'd4);
        press(4'd5);
        @(negedge clk);
        cancel_key = 1'b1;
        start_key  = 1'b1;
        @(negedge clk);
        cancel_key = 1'b0;
        start_key  = 1'b0;
        check("cs_dig", digits, 16'h0000);
        check("cs_entry", 16'(entry_active), 16'h0);
        repeat (3) @(negedge clk);
        check("cs_noload", 16'(pulses - p0), 16'h0);

        // Start in IDLE with zero buffer.
        @(negedge clk);
        start_key = 1'b1;
        @(negedge clk);
        start_key = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_start", 16'(pulses - p0), 16'h0);

        // Start in ENTRY with all-zero digits returns to IDLE.
        press(4'd0);
        check("zero_entry", 16'(entry_active), 16'h1);
        @(negedge clk);
        start_key = 1'b1;
        @(negedge clk);
        start_key = 1'b0;
        check("zero_idle", 16'(entry_active), 16'h0);
        repeat (3) @(negedge clk);
        check("zero_noload", 16'(pulses - p0), 16'h0);

        // Busy timer blocks keys and start, not cancel.
        press(4'd2);
        timer_busy = 1'b1;
        press(4'd7);
        @(negedge clk);
        start_key = 1'b1;
        @(negedge clk);
        start_key = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_dig", digits, 16'h0002);
        check("busy_entry", 16'(entry_active), 16'h1);
        check("busy_noload", 16'(pulses - p0), 16'h0);
        cancel();
        check("busy_cancel", digits, 16'h0000);
        check("busy_cidle", 16'(entry_active), 16'h0);
        timer_busy = 1'b0;

        // Clear during NORMALIZE.
        press(4'd9);
        press(4'd0);
        @(negedge clk);
        start_key = 1'b1;
        @(negedge clk);
        start_key = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_dig", digits, 16'h0000);
        check("clr_load", 16'(load), 16'h0);
        check("clr_entry", 16'(entry_active), 16'h0);
        repeat (3) @(negedge clk);
        check("clr_noload", 16'(pulses - p0), 16'h0);

        // Cancel during LOAD: strobe completes, buffer cleared after.
        press(4'd1);
        @(negedge clk);
        start_key = 1'b1;
        @(negedge clk);
        start_key = 1'b0;
        @(negedge clk);
        check("cl_load_hi", 16'(load), 16'h1);
        check("cl_load_dig", digits, 16'h0001);
        cancel_key = 1'b1;
        @(negedge clk);
        cancel_key = 1'b0;
        check("cl_load_lo", 16'(load), 16'h0);
        check("cl_dig", digits, 16'h0000);
        check("cl_one", 16'(pulses - p0), 16'h1);

        // Non-digit code in ENTRY.
        press(4'd3);
        press(4'd12);
        check("code12_dig", digits, 16'h0003);
        check("code12_entry", 16'(entry_active), 16'h1);
        cancel();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
